dmem_port_arbiter: RTL and testbench

- Shares the single-port dmem syncram between two requesters: port 0 is the processor's load/store path, port 1 is a secondary master (program loader / debug DMA).
- Arbitrates per cycle with round-robin fairness and forwards the winning request to the dmem pins.
- Routes the 1-cycle-latency read data back to whichever requester issued the read.
- Sits in skeleton between the processor's address_dmem/data/wren/q_dmem nets and dmem.

---
 rtl/dmem_arb_pkg.sv | 21 ++
 rtl/dmem_rd_tag_pipe.sv | 30 +++
 rtl/dmem_port_arbiter.sv | 176 +++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared constants and types for the dmem port arbiter.
package dmem_arb_pkg;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    localparam int unsigned ADDR_W_DEF = 12;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_LOCK1 = 1'b1
    } arb_state_e;

    // Read-return tag: which port issued the read still in flight.
    typedef struct packed {
        logic valid;
        logic port;
    } rd_tag_t;

endpackage

// File: rtl/dmem_rd_tag_pipe.sv
// RD_LAT-deep shift register of read tags, aligned with the dmem read latency.
module dmem_rd_tag_pipe
    import dmem_arb_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic    clock,
    input  logic    reset,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t stage [RD_LAT];

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < int'(RD_LAT); i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[RD_LAT-1];

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-port round-robin arbiter in front of the single-port dmem syncram.
// Optional port-1 lock ownership is built when DMEM_ARB_LOCK_EN is defined.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned MAX_LOCK = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req0_wren,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    input  logic              req1_wren,
    input  logic              req1_lock,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    logic              last_winner;
    logic              lock_hold;
    logic              lock_exit;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;
    rd_tag_t           tag_in;
    rd_tag_t           tag_out;

`ifdef DMEM_ARB_LOCK_EN
    localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);

    arb_state_e       state;
    logic [CNT_W-1:0] lock_cnt;
    logic [CNT_W-1:0] cnt_inc;

    assign lock_hold = (state == ARB_LOCK1);
    assign cnt_inc   = lock_cnt + CNT_W'(1);
    // Lock ends after the grant that brings the run to MAX_LOCK cycles.
    assign lock_exit = lock_hold && (!req1 || !req1_lock || (cnt_inc >= CNT_W'(MAX_LOCK)));

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= ARB_RR;
            lock_cnt <= '0;
        end else begin
            case (state)
                ARB_RR: begin
                    if (gnt1 && req1_lock && (MAX_LOCK > 1)) begin
                        state    <= ARB_LOCK1;
                        lock_cnt <= CNT_W'(1);
                    end
                end
                ARB_LOCK1: begin
                    if (lock_exit) begin
                        state    <= ARB_RR;
                        lock_cnt <= '0;
                    end else if (gnt1) begin
                        lock_cnt <= cnt_inc;
                    end
                end
                default: begin
                    state    <= ARB_RR;
                    lock_cnt <= '0;
                end
            endcase
        end
    end
`else
    logic [32:0] unused_lock;

    assign lock_hold   = 1'b0;
    assign lock_exit   = 1'b0;
    assign unused_lock = {req1_lock, 32'(MAX_LOCK)};
`endif

    // Per-cycle grant; nothing is granted while reset is held low.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset) begin
            if (lock_hold && req1) begin
                gnt1 = 1'b1;
            end else if (req0 && req1) begin
                gnt0 = (last_winner == PORT_AUX);
                gnt1 = (last_winner == PORT_CPU);
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    // Winner drives the pins; idle cycles replay the last address/data with wren low.
    always_comb begin
        mem_address = addr_q;
        mem_data    = data_q;
        mem_wren    = 1'b0;
        if (gnt0) begin
            mem_address = req0_addr;
            mem_data    = req0_wdata;
            mem_wren    = req0_wren;
        end else if (gnt1) begin
            mem_address = req1_addr;
            mem_data    = req1_wdata;
            mem_wren    = req1_wren;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            last_winner <= PORT_AUX;
            addr_q      <= '0;
            data_q      <= '0;
        end else begin
            if (lock_exit) begin
                last_winner <= PORT_AUX;
            end else if (gnt0) begin
                last_winner <= PORT_CPU;
            end else if (gnt1) begin
                last_winner <= PORT_AUX;
            end
            if (gnt0 || gnt1) begin
                addr_q <= mem_address;
                data_q <= mem_data;
            end
        end
    end

    assign tag_in.valid = (gnt0 && !req0_wren) || (gnt1 && !req1_wren);
    assign tag_in.port  = gnt1 ? PORT_AUX : PORT_CPU;

    dmem_rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .clock   (clock),
        .reset   (reset),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    // Returning tag steers mem_q to its port; the other port keeps its last data.
    assign rvalid0 = reset && tag_out.valid && (tag_out.port == PORT_CPU);
    assign rvalid1 = reset && tag_out.valid && (tag_out.port == PORT_AUX);
    assign rdata0  = rvalid0 ? mem_q : rdata0_q;
    assign rdata1  = rvalid1 ? mem_q : rdata1_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            if (rvalid0) begin
                rdata0_q <= mem_q;
            end
            if (rvalid1) begin
                rdata1_q <= mem_q;
            end
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a 1-cycle syncram model behind it.
module tb_dmem_port_arbiter;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 32;

    logic              clock;
    logic              reset;
    logic              req0, req0_wren, gnt0, rvalid0;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata, rdata0;
    logic              req1, req1_wren, req1_lock, gnt1, rvalid1;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata, rdata1;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data, mem_q;
    logic              mem_wren;

    int checks;
    int errors;

    dmem_port_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .RD_LAT   (1),
        .MAX_LOCK (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req0        (req0),
        .req0_addr   (req0_addr),
        .req0_wdata  (req0_wdata),
        .req0_wren   (req0_wren),
        .gnt0        (gnt0),
        .rvalid0     (rvalid0),
        .rdata0      (rdata0),
        .req1        (req1),
        .req1_addr   (req1_addr),
        .req1_wdata  (req1_wdata),
        .req1_wren   (req1_wren),
        .req1_lock   (req1_lock),
        .gnt1        (gnt1),
        .rvalid1     (rvalid1),
        .rdata1      (rdata1),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_wren    (mem_wren),
        .mem_q       (mem_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Syncram model: unwritten words read as 0xC0DE0000 | address.
    logic [DATA_W-1:0] mem_store [4096];
    bit                mem_written [4096];

    always @(posedge clock) begin
        if (mem_wren) begin
            mem_store[mem_address]   <= mem_data;
            mem_written[mem_address] <= 1'b1;
        end
        mem_q <= mem_written[mem_address] ? mem_store[mem_address]
                                          : (32'hC0DE_0000 | 32'(mem_address));
    end

    task automatic idle_all();
        req0 = 1'b0; req0_wren = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1 = 1'b0; req1_wren = 1'b0; req1_addr = '0; req1_wdata = '0;
        req1_lock = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_all();
        req0 = 1'b1; req0_wren = 1'b1; req0_addr = 12'h0AA;
        req1 = 1'b1; req1_wren = 1'b1; req1_addr = 12'h0BB;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({gnt0, gnt1, mem_wren} !== 3'b000) begin
            errors++;
            $display("FAIL reset_gnt_wren: got %b expected 000", {gnt0, gnt1, mem_wren});
        end
        checks++;
        if ({rvalid0, rvalid1} !== 2'b00) begin
            errors++;
            $display("FAIL reset_rvalid: got %b expected 00", {rvalid0, rvalid1});
        end
        checks++;
        if ({rdata0, rdata1} !== 64'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h expected 0", {rdata0, rdata1});
        end
    endtask

    task automatic test_contention();
        @(posedge clock); #1;
        reset = 1'b1;
        idle_all();
        req0 = 1'b1; req0_addr = 12'h010;
        req1 = 1'b1; req1_addr = 12'h020;
        @(negedge clock);
        checks++;
        if ({gnt0, gnt1, mem_wren, mem_address} !== {3'b100, 12'h010}) begin
            errors++;
            $display("FAIL contention_first: got %b/%h expected 100/010", {gnt0, gnt1, mem_wren}, mem_address);
        end
        @(posedge clock); #1;
        req0 = 1'b0;
        @(negedge clock);
        checks++;
        if ({gnt0, gnt1, mem_address} !== {2'b01, 12'h020}) begin
            errors++;
            $display("FAIL contention_second: got %b/%h expected 01/020", {gnt0, gnt1}, mem_address);
        end
        checks++;
        if ({rvalid0, rvalid1, rdata0} !== {2'b10, 32'hC0DE_0010}) begin
            errors++;
            $display("FAIL contention_ret0: got %b/%h expected 10/c0de0010", {rvalid0, rvalid1}, rdata0);
        end
        @(posedge clock); #1;
        req1 = 1'b0;
        @(negedge clock);
        checks++;
        if ({rvalid0, rvalid1, rdata1} !== {2'b01, 32'hC0DE_0020}) begin
            errors++;
            $display("FAIL contention_ret1: got %b/%h expected 01/c0de0020", {rvalid0, rvalid1}, rdata1);
        end
        checks++;
        if (rdata0 !== 32'hC0DE_0010) begin
            errors++;
            $display("FAIL contention_rdata0_hold: got %h expected c0de0010", rdata0);
        end
        checks++;
        if ({gnt0, gnt1, mem_wren, mem_address} !== {3'b000, 12'h020}) begin
            errors++;
            $display("FAIL contention_idle: got %b/%h expected 000/020", {gnt0, gnt1, mem_wren}, mem_address);
        end
    endtask

    task automatic test_single_stream();
        @(posedge clock); #1;
        req1 = 1'b1; req1_wren = 1'b1; req1_addr = 12'h005; req1_wdata = 32'hDEAD_BEEF;
        @(negedge clock);
        checks++;
        if ({gnt0, gnt1, mem_wren, mem_address, mem_data} !== {3'b011, 12'h005, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL single_write: got %b/%h/%h expected 011/005/deadbeef", {gnt0, gnt1, mem_wren}, mem_address, mem_data);
        end
        @(posedge clock); #1;
        req1_wren = 1'b0;
        @(negedge clock);
        checks++;
        if ({gnt0, gnt1, mem_wren, rvalid0, rvalid1} !== 5'b01000) begin
            errors++;
            $display("FAIL single_read: got %b expected 01000", {gnt0, gnt1, mem_wren, rvalid0, rvalid1});
        end
        @(posedge clock); #1;
        req1 = 1'b0;
        @(negedge clock);
        checks++;
        if ({rvalid0, rvalid1, rdata1} !== {2'b01, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL single_return: got %b/%h expected 01/deadbeef", {rvalid0, rvalid1}, rdata1);
        end
        checks++;
        if ({mem_wren, mem_address, mem_data} !== {1'b0, 12'h005, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL single_idle_hold: got %b/%h/%h expected 0/005/deadbeef", mem_wren, mem_address, mem_data);
        end
        @(posedge clock); #1;
        @(negedge clock);
        checks++;
        if ({rvalid0, rvalid1, rdata1} !== {2'b00, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL single_pulse_once: got %b/%h expected 00/deadbeef", {rvalid0, rvalid1}, rdata1);
        end
    endtask

    task automatic test_fair_alternation();
        logic [ADDR_W-1:0] prev_addr;
        int                n0, n1;
        n0 = 0; n1 = 0;
        prev_addr = '0;
        for (int k = 0; k <= 8; k++) begin
            @(posedge clock); #1;
            if (k < 8) begin
                req0 = 1'b1; req0_addr = 12'h100 + 12'((k + 1) / 2);
                req1 = 1'b1; req1_addr = 12'h200 + 12'(k / 2);
            end else begin
                req0 = 1'b0; req1 = 1'b0;
            end
            @(negedge clock);
            if (rvalid0) n0++;
            if (rvalid1) n1++;
            if (k < 8) begin
                checks++;
                if ({gnt0, gnt1} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
                    errors++;
                    $display("FAIL fair_grant_%0d: got %b expected %b", k, {gnt0, gnt1}, (k % 2 == 0) ? 2'b10 : 2'b01);
                end
            end
            if (k >= 1) begin
                checks++;
                if ((k - 1) % 2 == 0) begin
                    if ({rvalid0, rvalid1, rdata0} !== {2'b10, 32'hC0DE_0000 | 32'(prev_addr)}) begin
                        errors++;
                        $display("FAIL fair_return_%0d: got %b/%h expected 10/%h", k, {rvalid0, rvalid1}, rdata0, 32'hC0DE_0000 | 32'(prev_addr));
                    end
                end else begin
                    if ({rvalid0, rvalid1, rdata1} !== {2'b01, 32'hC0DE_0000 | 32'(prev_addr)}) begin
                        errors++;
                        $display("FAIL fair_return_%0d: got %b/%h expected 01/%h", k, {rvalid0, rvalid1}, rdata1, 32'hC0DE_0000 | 32'(prev_addr));
                    end
                end
            end
            prev_addr = (k % 2 == 0) ? 12'h100 + 12'(k / 2) : 12'h200 + 12'(k / 2);
        end
        checks++;
        if (n0 != 4 || n1 != 4) begin
            errors++;
            $display("FAIL fair_pulse_count: got %0d/%0d expected 4/4", n0, n1);
        end
    endtask

    task automatic test_reset_mid_read();
        @(posedge clock); #1;
        idle_all();
        req0 = 1'b1; req0_addr = 12'h030;
        @(negedge clock);
        checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            errors++;
            $display("FAIL midreset_grant: got %b expected 10", {gnt0, gnt1});
        end
        @(posedge clock); #1;
        reset = 1'b0;
        req0 = 1'b1; req0_wren = 1'b1;
        req1 = 1'b1; req1_wren = 1'b1; req1_addr = 12'h031;
        @(negedge clock);
        checks++;
        if ({gnt0, gnt1, mem_wren, rvalid0, rvalid1} !== 5'b00000) begin
            errors++;
            $display("FAIL midreset_held: got %b expected 00000", {gnt0, gnt1, mem_wren, rvalid0, rvalid1});
        end
        @(posedge clock); #1;
        @(negedge clock);
        checks++;
        if ({rvalid0, rvalid1, rdata0, rdata1} !== {2'b00, 64'h0}) begin
            errors++;
            $display("FAIL midreset_cleared: got %b/%h/%h expected 00/0/0", {rvalid0, rvalid1}, rdata0, rdata1);
        end
        @(posedge clock); #1;
        reset = 1'b1;
        idle_all();
        @(negedge clock);
        checks++;
        if ({gnt0, gnt1, rvalid0, rvalid1} !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_after: got %b expected 0000", {gnt0, gnt1, rvalid0, rvalid1});
        end
    endtask

    task automatic test_lock();
        logic [6:0] exp1;
`ifdef DMEM_ARB_LOCK_EN
        exp1 = 7'b0111101;
`else
        exp1 = 7'b0101010;
`endif
        for (int k = 0; k < 7; k++) begin
            @(posedge clock); #1;
            req0 = 1'b1; req0_addr = 12'h040;
            req1 = 1'b1; req1_addr = 12'h050; req1_lock = 1'b1;
            @(negedge clock);
            checks++;
            if ({gnt0, gnt1} !== {~exp1[6-k], exp1[6-k]}) begin
                errors++;
                $display("FAIL lock_grant_%0d: got %b expected %b", k, {gnt0, gnt1}, {~exp1[6-k], exp1[6-k]});
            end
        end
        @(posedge clock); #1;
        idle_all();
        repeat (2) @(posedge clock);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_contention();
        test_single_stream();
        test_fair_alternation();
        test_reset_mid_read();
        test_lock();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
